ysyx_22040127_iter_div: RTL and testbench

//  Iterative radix-2 restoring divider: the responder behind the execute stage's divide handshake.
//  - Serves DIV/DIVU/REM/REMU and, through operands pre-extended by execute, the 32-bit W forms.
//  - Execute holds is_div until div_ready, and stalls while div_state is 01 or 10.
//  - Produces the quotient and remainder together, one quotient bit per cycle.

---
 rtl/ysyx_22040127_iter_div.sv | 135 +++++++++++++
 tb/tb_ysyx_22040127_iter_div.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040127_iter_div.sv
// Iterative radix-2 restoring divider: quotient and remainder together, one quotient bit per cycle.
// Optional macro YSYX_22040127_DIV_FAST_ZERO_EN: a start with a zero divisor jumps straight to DONE.
module ysyx_22040127_iter_div #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             s,
  input  logic             is_div,
  input  logic             div_ack,
  input  logic             flush,
  output logic             div_ready,
  output logic [1:0]       div_state,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_SIGN = 2'b10,
    S_DONE = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_y_zero;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;

  logic [WIDTH-1:0] w_x_abs;
  logic [WIDTH-1:0] w_y_abs;
  logic             w_y_zero;
  logic [WIDTH:0]   w_trial;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_prem_nxt;

  // The most negative value negates to itself, which read as unsigned is exactly its magnitude.
  assign w_x_abs  = (s && x[WIDTH-1]) ? -x : x;
  assign w_y_abs  = (s && y[WIDTH-1]) ? -y : y;
  assign w_y_zero = (y == '0);

  // Trial subtraction needs one extra bit: the shifted partial remainder can reach 2*|y|-1.
  assign w_trial    = {r_prem, r_dvd[WIDTH-1]};
  assign w_q_bit    = (w_trial >= {1'b0, r_dsr});
  assign w_prem_nxt = w_q_bit ? WIDTH'(w_trial - {1'b0, r_dsr}) : w_trial[WIDTH-1:0];

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (is_div) begin
`ifdef YSYX_22040127_DIV_FAST_ZERO_EN
          w_next = w_y_zero ? S_DONE : S_CALC;
`else
          w_next = S_CALC;
`endif
        end
        S_CALC: if (r_cnt == LAST_ITER) w_next = S_SIGN;
        S_SIGN: w_next = S_DONE;
        S_DONE: if (div_ack) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_prem   <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_y_zero <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
    end else if (!flush) begin
      unique case (r_state)
        S_IDLE: if (is_div) begin
          r_cnt    <= '0;
          r_prem   <= '0;
          r_dvd    <= w_x_abs;
          r_dsr    <= w_y_abs;
          r_neg_q  <= s & (x[WIDTH-1] ^ y[WIDTH-1]);
          r_neg_r  <= s & x[WIDTH-1];
          r_y_zero <= w_y_zero;
`ifdef YSYX_22040127_DIV_FAST_ZERO_EN
          if (w_y_zero) begin
            r_quo <= '1;
            r_rem <= x;
          end
`endif
        end
        S_CALC: begin
          r_prem <= w_prem_nxt;
          r_dvd  <= {r_dvd[WIDTH-2:0], w_q_bit};
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        S_SIGN: begin
          // A zero divisor leaves an all-ones quotient that must not be negated.
          r_quo <= (r_neg_q && !r_y_zero) ? -r_dvd : r_dvd;
          r_rem <= r_neg_r ? -r_prem : r_prem;
        end
        default: ;
      endcase
    end
  end

  assign div_ready = (r_state == S_DONE);
  assign div_state = r_state;
  assign quo       = r_quo;
  assign rem       = r_rem;

endmodule

// File: tb/tb_ysyx_22040127_iter_div.sv
// Self-checking bench for ysyx_22040127_iter_div: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_ysyx_22040127_iter_div;

  localparam int WIDTH   = 64;
  localparam int TIMEOUT = 300;
`ifdef YSYX_22040127_DIV_FAST_ZERO_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = WIDTH + 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             s;
  logic             is_div;
  logic             div_ack;
  logic             flush;
  logic             div_ready;
  logic [1:0]       div_state;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] last_r;

  ysyx_22040127_iter_div #(.WIDTH(WIDTH), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .s(s), .is_div(is_div), .div_ack(div_ack),
    .flush(flush), .div_ready(div_ready), .div_state(div_state), .quo(quo), .rem(rem)
  );

  always #5 clk = ~clk;

  // RISC-V division semantics computed with plain integer arithmetic.
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input bit sg,
                                  output logic [63:0] q, output logic [63:0] r);
    longint sa, sb;
    sa = a;
    sb = b;
    if (b == 64'd0) begin
      q = '1;
      r = a;
    end else if (sg) begin
      if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a;
        r = '0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic note(input bit ok, input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Called at a negedge; presents a start request that the next posedge samples.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input bit sg);
    x = a;
    y = b;
    s = sg;
    is_div = 1'b1;
  endtask

  // Counts edges from the sampling edge until div_ready, tallying CALC/SIGN cycles on the way.
  task automatic wait_done(output int edges, output int n_calc, output int n_sign, output bit to);
    edges = 0; n_calc = 0; n_sign = 0; to = 1'b0;
    forever begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (div_state == 2'b01) n_calc++;
      if (div_state == 2'b10) n_sign++;
      if (div_ready) break;
      if (edges >= TIMEOUT) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_ack();
    is_div  = 1'b0;
    div_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_ack = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit sg, input bit ack,
                        output logic [63:0] q, output logic [63:0] r, output int edges, output bit to);
    int nc, ns;
    start_op(a, b, sg);
    wait_done(edges, nc, ns, to);
    q = quo;
    r = rem;
    last_q = quo;
    last_r = rem;
    if (ack) do_ack();
  endtask

  task automatic test_reset();
    rst = 1'b1; x = '0; y = '0; s = 1'b0; is_div = 1'b0; div_ack = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (div_state !== 2'b00) begin n_checks++; $display("FAIL reset_state: got %0d expected 0", div_state); end
    else begin n_checks++; n_pass++; end
    if (div_ready !== 1'b0) begin n_checks++; $display("FAIL reset_ready: got %b expected 0", div_ready); end
    else begin n_checks++; n_pass++; end
    if (quo !== '0 || rem !== '0) begin n_checks++; $display("FAIL reset_quo_rem: got %h/%h expected 0/0", quo, rem); end
    else begin n_checks++; n_pass++; end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int edges, nc, ns;
    bit to;
    start_op(64'd100, 64'd7, 1'b0);
    wait_done(edges, nc, ns, to);
    note(!to, "basic_timeout", 64'(edges), 64'(WIDTH + 2));
    note(edges == WIDTH + 2, "basic_latency", 64'(edges), 64'(WIDTH + 2));
    note(nc == WIDTH, "basic_calc_cycles", 64'(nc), 64'(WIDTH));
    note(ns == 1, "basic_sign_cycles", 64'(ns), 64'd1);
    note(div_state === 2'b11, "basic_done_state", 64'(div_state), 64'd3);
    note(quo === 64'd14, "basic_quo", quo, 64'd14);
    note(rem === 64'd2, "basic_rem", rem, 64'd2);
    last_q = quo;
    last_r = rem;
    do_ack();
    note(div_state === 2'b00, "basic_ack_idle", 64'(div_state), 64'd0);
  endtask

  task automatic test_signs();
    logic [63:0] q, r;
    int edges;
    bit to;
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, q, r, edges, to);
    note(!to && q === 64'hFFFF_FFFF_FFFF_FFFD, "signed_quo", q, 64'hFFFF_FFFF_FFFF_FFFD);
    note(!to && r === 64'hFFFF_FFFF_FFFF_FFFF, "signed_rem", r, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, q, r, edges, to);
    note(!to && q === 64'h7FFF_FFFF_FFFF_FFFC, "unsigned_quo", q, 64'h7FFF_FFFF_FFFF_FFFC);
    note(!to && r === 64'd1, "unsigned_rem", r, 64'd1);
  endtask

  task automatic test_corners();
    logic [63:0] q, r;
    int edges;
    bit to;
    run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, q, r, edges, to);
    note(!to && q === 64'h8000_0000_0000_0000, "overflow_quo", q, 64'h8000_0000_0000_0000);
    note(!to && r === 64'd0, "overflow_rem", r, 64'd0);
    run_op(64'd5, 64'd0, 1'b1, 1'b1, q, r, edges, to);
    note(!to && q === 64'hFFFF_FFFF_FFFF_FFFF, "divzero_quo", q, 64'hFFFF_FFFF_FFFF_FFFF);
    note(!to && r === 64'd5, "divzero_rem", r, 64'd5);
    note(edges == ZERO_LAT, "divzero_latency", 64'(edges), 64'(ZERO_LAT));
    run_op(64'hFFFF_FFFF_FFFF_FFF6, 64'd0, 1'b1, 1'b1, q, r, edges, to);
    note(!to && q === 64'hFFFF_FFFF_FFFF_FFFF, "divzero_neg_quo", q, 64'hFFFF_FFFF_FFFF_FFFF);
    note(!to && r === 64'hFFFF_FFFF_FFFF_FFF6, "divzero_neg_rem", r, 64'hFFFF_FFFF_FFFF_FFF6);
  endtask

  task automatic test_random();
    logic [63:0] a, b, q, r, eq, er;
    bit sg, to;
    int edges;
    for (int i = 0; i < 40; i++) begin
      a  = {$urandom, $urandom};
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = 64'($urandom_range(0, 15));
        1:       b = -64'($urandom_range(1, 15));
        2:       b = {32'd0, $urandom};
        default: b = {$urandom, $urandom};
      endcase
      if (i % 8 == 7) a = 64'h8000_0000_0000_0000;
      ref_div(a, b, sg, eq, er);
      run_op(a, b, sg, 1'b1, q, r, edges, to);
      if (to || q !== eq || r !== er) begin
        n_checks++;
        $display("FAIL random_%0d: x=%h y=%h s=%b got q=%h r=%h expected q=%h r=%h",
                 i, a, b, sg, q, r, eq, er);
      end else begin
        n_checks++;
        n_pass++;
      end
    end
  endtask

  task automatic test_hold_done();
    logic [63:0] q, r, eq, er;
    int edges, nc, ns;
    bit to, ok;
    run_op(64'd1000, 64'd33, 1'b0, 1'b0, q, r, edges, to);
    ok = !to;
    for (int i = 0; i < 10; i++) begin
      is_div = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      if (div_ready !== 1'b1 || div_state !== 2'b11 || quo !== q || rem !== r) ok = 1'b0;
    end
    note(ok, "hold_done_stable", quo, q);
    do_ack();
    note(div_state === 2'b00, "hold_ack_idle", 64'(div_state), 64'd0);
    start_op(64'd9, 64'd3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    note(div_state === 2'b01, "restart_calc", 64'(div_state), 64'd1);
    wait_done(edges, nc, ns, to);
    ref_div(64'd9, 64'd3, 1'b0, eq, er);
    note(!to && quo === eq && rem === er, "restart_result", quo, eq);
    last_q = quo;
    last_r = rem;
    do_ack();
  endtask

  task automatic test_flush();
    logic [63:0] q, r;
    int edges;
    bit to, rose;
    start_op(64'd123456789, 64'd789, 1'b0);
    repeat (20) begin @(posedge clk); @(negedge clk); end
    div_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_ack = 1'b0;
    note(div_state === 2'b01, "ack_ignored_calc", 64'(div_state), 64'd1);
    repeat (10) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    is_div = 1'b0;
    note(div_state === 2'b00, "flush_idle", 64'(div_state), 64'd0);
    rose = 1'b0;
    repeat (80) begin
      @(posedge clk);
      @(negedge clk);
      if (div_ready) rose = 1'b1;
    end
    note(!rose, "flush_no_ready", 64'(rose), 64'd0);
    note(quo === last_q && rem === last_r, "flush_keeps_result", quo, last_q);
    run_op(64'd9, 64'd3, 1'b0, 1'b1, q, r, edges, to);
    note(!to && q === 64'd3 && r === 64'd0, "after_flush_9_3", q, 64'd3);
  endtask

  task automatic test_rst_mid();
    logic [63:0] q, r;
    int edges;
    bit to;
    start_op(64'hFFFF_0000_1234_5678, 64'd77, 1'b1);
    repeat (41) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    is_div = 1'b0;
    note(div_state === 2'b00 && div_ready === 1'b0, "rst_mid_idle", 64'(div_state), 64'd0);
    note(quo === '0 && rem === '0, "rst_mid_clears", quo | rem, 64'd0);
    run_op(64'd9, 64'd3, 1'b0, 1'b1, q, r, edges, to);
    note(!to && q === 64'd3 && r === 64'd0, "after_rst_9_3", q, 64'd3);
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_basic();
    test_signs();
    test_corners();
    test_random();
    test_hold_done();
    test_flush();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
